// File: rtl/uat_seq_adder.sv
// Multi-word adder/subtractor: one 16-bit carry-lookahead stage, time-shared
// across WORDS chunks (LSB first) with the carry held in a register between chunks.

module uat_seq_adder_cla16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        c_i,
   output logic [15:0] s_o,
   output logic        c_o
);
   logic [15:0] g, p;
   logic [16:0] c;
   logic [3:0]  gg, pg;

   // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
   always_comb begin
      g  = a_i & b_i;
      p  = a_i ^ b_i;
      c  = '0;
      gg = '0;
      pg = '0;
      for (int k = 0; k < 4; k++) begin
         gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         pg[k] = &p[4*k +: 4];
      end
      // Group carries come from two-level lookahead, not a ripple through the groups.
      c[0]  = c_i;
      c[4]  = gg[0] | (pg[0] & c_i);
      c[8]  = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c_i);
      c[12] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & c_i);
      c[16] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0])
            | (&pg & c_i);
      for (int k = 0; k < 4; k++) begin
         c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      end
      s_o = p ^ c[15:0];
      c_o = c[16];
   end
endmodule

module uat_seq_adder #(
   parameter int WORDS = 4,
   parameter int WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WORDS*WIDTH-1:0] a,
   input  logic [WORDS*WIDTH-1:0] b,
   input  logic                   cin,
   input  logic                   op_sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WORDS*WIDTH-1:0] res,
   output logic                   cout
);
   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                       state_q, state_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic                         carry_q, carry_d;
   logic                         cout_q, cout_d;
   logic [WORDS-1:0][WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
   logic [WIDTH-1:0]             sum;
   logic                         sum_c;

   uat_seq_adder_cla16 u_cla (
      .a_i (a_q[cnt_q]),
      .b_i (b_q[cnt_q]),
      .c_i (carry_q),
      .s_o (sum),
      .c_o (sum_c)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      case (state_q)
         IDLE: if (in_valid) begin
            a_d     = a;
            // Subtraction is A + ~B + 1: invert B here and force the carry-in.
            b_d     = op_sub ? ~b : b;
            carry_d = op_sub ? 1'b1 : cin;
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            res_d[cnt_q] = sum;
            carry_d      = sum_c;
            if (cnt_q == CW'(WORDS - 1)) begin
               cout_d  = sum_c;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         res_q   <= res_d;
      end
   end

   // NOTE: operand registers are always loaded before use, so they carry no reset.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign res       = res_q;
   assign cout      = cout_q;
endmodule
